// File: rtl/io_controller_pkg.sv
// Shared constants for the I/O request responder: word width, size codes and FSM states.
package io_controller_pkg;

  localparam int IO_LEN_WORD = 32;

  localparam logic [1:0] IO_SIZE_B = 2'd0;
  localparam logic [1:0] IO_SIZE_H = 2'd1;
  localparam logic [1:0] IO_SIZE_W = 2'd2;

  localparam logic [1:0] IO_ST_IDLE = 2'd0;
  localparam logic [1:0] IO_ST_TX   = 2'd1;
  localparam logic [1:0] IO_ST_RX   = 2'd2;
  localparam logic [1:0] IO_ST_DONE = 2'd3;

  // Size code 3 is treated as a full word, same as IO_SIZE_W.
  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    case (size)
      IO_SIZE_B: return 3'd1;
      IO_SIZE_H: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/io_rx_fifo.sv
// Byte FIFO buffering the UART receive stream; pointers carry one extra wrap bit.
// A push into a full FIFO only lands when a pop frees a slot that same cycle; otherwise overflow sticks.
module io_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       push,
  input  logic [7:0] data_in,
  input  logic       pop,
  output logic [7:0] data_out,
  output logic       empty,
  output logic       full,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign data_out = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !do_push) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_controller.sv
// Responder for one I/O order at a time: writes stream bytes to UART TX, reads assemble bytes
// from the RX FIFO. Accepted one cycle after the order; done one cycle after the last byte moves.
module io_controller
  import io_controller_pkg::*;
#(
  parameter int RX_DEPTH = 16,
  parameter int LEN_WORD = IO_LEN_WORD
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                io_order,
  output logic                io_accepted,
  output logic                io_done,
  input  logic                io_write_flag,
  input  logic [1:0]          io_size,
  input  logic [LEN_WORD-1:0] io_o_data,
  output logic [LEN_WORD-1:0] io_i_data,
  output logic [7:0]          uart_tx_data,
  output logic                uart_tx_valid,
  input  logic                uart_tx_ready,
  input  logic [7:0]          uart_rx_data,
  input  logic                uart_rx_valid,
  output logic                rx_overflow
);

  logic [1:0]          state;
  logic [2:0]          nbytes;
  logic [1:0]          k;
  logic [1:0]          k_next;
  logic                last_byte;
  logic [LEN_WORD-1:0] wdata;
  logic [31:0]         asm_q;
  logic [31:0]         asm_next;
  logic                fifo_empty;
  logic                fifo_pop;
  logic [7:0]          fifo_dout;

  assign k_next    = k + 2'd1;
  assign last_byte = ({1'b0, k} == (nbytes - 3'd1));
  assign fifo_pop  = (state == IO_ST_RX) && !fifo_empty;

  // Drop the popped byte into lane k; lanes above are still zero from the accept.
  always_comb begin
    asm_next = asm_q;
    asm_next[{k, 3'b000} +: 8] = fifo_dout;
  end

  io_rx_fifo #(
    .DEPTH(RX_DEPTH)
  ) u_rx_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (uart_rx_valid),
    .data_in  (uart_rx_data),
    .pop      (fifo_pop),
    .data_out (fifo_dout),
    .empty    (fifo_empty),
    .full     (),
    .overflow (rx_overflow)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IO_ST_IDLE;
      nbytes        <= 3'd1;
      k             <= 2'd0;
      wdata         <= '0;
      asm_q         <= '0;
      io_accepted   <= 1'b0;
      io_done       <= 1'b0;
      io_i_data     <= '0;
      uart_tx_valid <= 1'b0;
      uart_tx_data  <= 8'd0;
    end else begin
      io_accepted <= 1'b0;
      io_done     <= 1'b0;
      case (state)
        IO_ST_IDLE: begin
          if (io_order) begin
            io_accepted <= 1'b1;
            nbytes      <= size_to_bytes(io_size);
            k           <= 2'd0;
            wdata       <= io_o_data;
            asm_q       <= '0;
            if (io_write_flag) begin
              state         <= IO_ST_TX;
              uart_tx_valid <= 1'b1;
              uart_tx_data  <= io_o_data[7:0];
            end else begin
              state <= IO_ST_RX;
            end
          end
        end
        IO_ST_TX: begin
          if (uart_tx_ready) begin
            if (last_byte) begin
              state         <= IO_ST_DONE;
              uart_tx_valid <= 1'b0;
              io_done       <= 1'b1;
            end else begin
              k            <= k_next;
              uart_tx_data <= wdata[{k_next, 3'b000} +: 8];
            end
          end
        end
        IO_ST_RX: begin
          if (!fifo_empty) begin
            asm_q <= asm_next;
            k     <= k_next;
            if (last_byte) begin
              state     <= IO_ST_DONE;
              io_i_data <= LEN_WORD'(asm_next);
              io_done   <= 1'b1;
            end
          end
        end
        default: begin
          state <= IO_ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_controller.sv
// Directed plus randomized bench for io_controller, checked against a queue-based byte model.
module tb_io_controller;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        io_order = 1'b0;
  logic        io_accepted;
  logic        io_done;
  logic        io_write_flag = 1'b0;
  logic [1:0]  io_size = 2'd0;
  logic [31:0] io_o_data = 32'd0;
  logic [31:0] io_i_data;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready = 1'b0;
  logic [7:0]  uart_rx_data = 8'd0;
  logic        uart_rx_valid = 1'b0;
  logic        rx_overflow;

  int total = 0;
  int bad = 0;

  // Reference model: bytes the FIFO should hold, sticky overflow, last read result.
  logic [7:0]  mq[$];
  logic [7:0]  pend[$];
  bit          m_ovf = 1'b0;
  logic [31:0] last_rd = 32'd0;

  always #5 clk = ~clk;

  io_controller #(
    .RX_DEPTH(DEPTH),
    .LEN_WORD(32)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .io_order      (io_order),
    .io_accepted   (io_accepted),
    .io_done       (io_done),
    .io_write_flag (io_write_flag),
    .io_size       (io_size),
    .io_o_data     (io_o_data),
    .io_i_data     (io_i_data),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .rx_overflow   (rx_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int nb(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_accepted"}, io_accepted, 0);
    chk({tag, "_done"}, io_done, 0);
    chk({tag, "_i_data"}, io_i_data, 0);
    chk({tag, "_tx_valid"}, uart_tx_valid, 0);
    chk({tag, "_tx_data"}, uart_tx_data, 0);
    chk({tag, "_overflow"}, rx_overflow, 0);
  endtask

  // Push one byte while the controller is idle (no pops can happen).
  task automatic push_byte(input logic [7:0] b);
    uart_rx_valid = 1'b1;
    uart_rx_data  = b;
    step();
    uart_rx_valid = 1'b0;
    if (mq.size() < DEPTH) mq.push_back(b);
    else m_ovf = 1'b1;
    chk("push_overflow", rx_overflow, m_ovf);
  endtask

  // Cycle numbering: the order is sampled at the end of cycle 0.
  task automatic do_write(input logic [1:0] sz, input logic [31:0] d, input int lowc,
                          input bit rmode, input bit hold);
    int n;
    int k;
    int cyc;
    bit r;
    n = nb(sz);
    k = 0;
    cyc = 1;
    io_order = 1'b1; io_write_flag = 1'b1; io_size = sz; io_o_data = d;
    uart_tx_ready = 1'b0;
    step();
    if (!hold) io_order = 1'b0;
    chk("wr_accepted", io_accepted, 1);
    while (k < n && cyc < 300) begin
      if (cyc > 1) chk("wr_accept_pulse", io_accepted, 0);
      chk("wr_no_early_done", io_done, 0);
      chk("tx_valid", uart_tx_valid, 1);
      chk("tx_data", uart_tx_data, d[8*k +: 8]);
      r = (cyc <= lowc) ? 1'b0 : (rmode ? 1'($urandom_range(0, 1)) : 1'b1);
      uart_tx_ready = r;
      step();
      cyc++;
      if (r) k++;
    end
    io_order = 1'b0;
    uart_tx_ready = 1'b0;
    chk("wr_all_bytes", k, n);
    chk("wr_done", io_done, 1);
    chk("tx_valid_off", uart_tx_valid, 0);
    chk("wr_keeps_rdata", io_i_data, last_rd);
    step();
    chk("wr_done_pulse", io_done, 0);
  endtask

  // Pushes bytes from pend every gap-th cycle while the read is outstanding.
  task automatic do_read(input logic [1:0] sz, input int gap, input bit hold);
    int n;
    int pre;
    int cyc;
    int pi;
    int p;
    int occ;
    int exp_done;
    int av[$];
    bit acc;
    logic [7:0] b;
    logic [31:0] exp;
    n = nb(sz);
    pre = mq.size();
    cyc = 1;
    pi = 0;
    exp_done = -1;
    for (int i = 0; i < pre && i < n; i++) av.push_back(1);
    io_order = 1'b1; io_write_flag = 1'b0; io_size = sz;
    step();
    if (!hold) io_order = 1'b0;
    chk("rd_accepted", io_accepted, 1);
    while (!io_done && cyc < 200) begin
      if (pi < pend.size() && (cyc % gap) == 0) begin
        b = pend[pi];
        pi++;
        uart_rx_valid = 1'b1;
        uart_rx_data  = b;
        occ = (pre >= n) ? mq.size() - ((cyc - 1 < n) ? cyc - 1 : n) : mq.size();
        acc = (occ < DEPTH) || (pre >= n && cyc <= n);
        if (acc) begin
          mq.push_back(b);
          if (av.size() < n) av.push_back(cyc + 1);
        end else begin
          m_ovf = 1'b1;
        end
      end else begin
        uart_rx_valid = 1'b0;
      end
      step();
      cyc++;
    end
    uart_rx_valid = 1'b0;
    io_order = 1'b0;
    chk("rd_done", io_done, 1);
    if (av.size() == n) begin
      p = 0;
      foreach (av[i]) p = (p + 1 > av[i]) ? p + 1 : av[i];
      exp_done = p + 1;
    end
    chk("rd_latency", cyc, exp_done);
    exp = 32'd0;
    for (int i = 0; i < n && mq.size() > 0; i++) exp |= 32'(mq.pop_front()) << (8 * i);
    last_rd = exp;
    chk("rd_data", io_i_data, exp);
    chk("rd_overflow", rx_overflow, m_ovf);
    step();
    chk("rd_done_pulse", io_done, 0);
    chk("rd_hold", io_i_data, last_rd);
  endtask

  initial begin
    logic [1:0] sz;
    int need;

    // Reset state
    #2;
    chk_all_zero("reset");
    step();
    step();
    rstn = 1'b1;
    step();
    chk("idle_done", io_done, 0);

    // Word write with ready tied high: bytes at cycles 1..4, done at 5
    do_write(2'd2, 32'hDEADBEEF, 0, 1'b0, 1'b0);

    // Byte write with ready held low for three cycles
    do_write(2'd0, 32'h12345678, 3, 1'b0, 1'b0);

    // Halfword read stalling on an empty FIFO
    pend = '{8'h34, 8'h12};
    do_read(2'd1, 3, 1'b0);
    chk("rd_h_value", io_i_data, 32'h00001234);

    // Word then byte read from six queued bytes; the sixth stays behind
    for (int i = 1; i <= 6; i++) push_byte(8'(i));
    pend.delete();
    do_read(2'd2, 1, 1'b0);
    chk("rd_w_value", io_i_data, 32'h04030201);
    do_read(2'd0, 1, 1'b0);
    chk("rd_b_value", io_i_data, 32'h00000005);
    do_read(2'd0, 1, 1'b0);
    chk("rd_leftover", io_i_data, 32'h00000006);

    // Overflow: DEPTH+1 pushes, then push and pop together while full
    for (int i = 0; i <= DEPTH; i++) push_byte(8'(8'hA0 + i));
    chk("ovf_set", rx_overflow, 1);
    pend = '{8'h5A};
    do_read(2'd0, 1, 1'b0);
    chk("ovf_first", io_i_data, 32'h000000A0);
    pend.delete();
    for (int i = 0; i < 4; i++) do_read(2'd2, 1, 1'b0);
    chk("ovf_tail", io_i_data, 32'h5AAFAEAD);

    // Reset in the middle of a word write
    io_order = 1'b1; io_write_flag = 1'b1; io_size = 2'd2; io_o_data = 32'hCAFEF00D;
    uart_tx_ready = 1'b1;
    step();
    io_order = 1'b0;
    step();
    step();
    rstn = 1'b0;
    #1;
    chk_all_zero("midrst");
    mq.delete();
    m_ovf = 1'b0;
    last_rd = 32'd0;
    uart_tx_ready = 1'b0;
    step();
    step();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("midrst_no_done", io_done, 0);
      chk("midrst_tx_idle", uart_tx_valid, 0);
    end
    do_write(2'd2, 32'h0BADCAFE, 0, 1'b0, 1'b0);

    // Randomized mix of reads and writes
    for (int it = 0; it < 30; it++) begin
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        do_write(sz, $urandom, $urandom_range(0, 2), 1'b1, 1'($urandom_range(0, 1)));
      end else begin
        for (int j = $urandom_range(0, 4); j > 0 && mq.size() < 8; j--) push_byte(8'($urandom));
        need = nb(sz) - mq.size();
        if (need < 0) need = 0;
        need = need + $urandom_range(0, 1);
        pend.delete();
        for (int j = 0; j < need; j++) pend.push_back(8'($urandom));
        do_read(sz, $urandom_range(1, 3), 1'($urandom_range(0, 1)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
